// File: rtl/pipe_skid_stage_pkg.sv
// Shared types and helpers for the pipe_skid_stage pipeline register.
// Build option: define PIPE_SKID_PERF_EN to add the stall/flush performance counters.

`ifndef HOLD_ENABLE
`define HOLD_ENABLE 1'b1
`endif
`ifndef JUMP_ENABLE
`define JUMP_ENABLE 1'b1
`endif
`ifndef RST_ENABLE
`define RST_ENABLE 1'b0
`endif

package pipe_skid_stage_pkg;

  localparam int unsigned OccW = 2;

  // Encoding is {push, pop} so the handshake pair can be cast directly.
  typedef enum logic [1:0] {
    XferNone = 2'b00,
    XferPop  = 2'b01,
    XferPush = 2'b10,
    XferBoth = 2'b11
  } xfer_e;

  typedef enum logic [1:0] {
    CtlRun   = 2'b00,
    CtlHold  = 2'b01,
    CtlFlush = 2'b10
  } ctl_e;

  function automatic logic [OccW-1:0] occ_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready/payload bundle for one side of a pipe_skid_stage.

interface pipe_skid_stage_if #(
  parameter int unsigned DATA_W = 160
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.

module pipe_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline register with hold (stall) and jump (flush) controls.
// Build option: PIPE_SKID_PERF_EN adds saturating stall/flush counters; otherwise they read 0.

module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned       DATA_W      = 160,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W       = 16
) (
  input  logic                    clk_100MHz,
  input  logic                    arst_n,
  input  logic                    hold_ena_i,
  input  logic                    jump_ena_i,
  pipe_skid_stage_if.slave        in_if,
  pipe_skid_stage_if.master       out_if,
  output logic [OccW-1:0]         occ_o,
  output logic [CNT_W-1:0]        stall_cnt_o,
  output logic [CNT_W-1:0]        flush_cnt_o
);

  logic rst, hold, jump;
  logic in_ready, out_valid, push, pop;
  ctl_e  ctl;
  xfer_e xfer;

  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic              main_v_q, main_v_d, skid_v_q, skid_v_d;

  assign rst  = (arst_n == `RST_ENABLE);
  assign hold = (hold_ena_i == `HOLD_ENABLE);
  assign jump = (jump_ena_i == `JUMP_ENABLE);

  // Jump outranks hold so a redirect issued during a stall is never lost.
  always_comb begin
    ctl = CtlRun;
    if (jump) begin
      ctl = CtlFlush;
    end else if (hold) begin
      ctl = CtlHold;
    end
  end

  assign in_ready  = !skid_v_q && !hold && !jump;
  assign out_valid = main_v_q && !hold && !jump;
  assign push      = in_if.valid && in_ready;
  assign pop       = out_valid && out_if.ready;
  assign xfer      = xfer_e'({push, pop});

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    unique case (ctl)
      CtlFlush: begin
        main_d   = BUBBLE_DATA;
        skid_d   = BUBBLE_DATA;
        main_v_d = 1'b0;
        skid_v_d = 1'b0;
      end
      CtlHold: begin
      end
      CtlRun: begin
        unique case (xfer)
          XferPush: begin
            if (!main_v_q) begin
              main_d   = in_if.data;
              main_v_d = 1'b1;
            end else begin
              skid_d   = in_if.data;
              skid_v_d = 1'b1;
            end
          end
          XferPop: begin
            // Vacated skid data is left in place; only its valid bit drops.
            main_d   = skid_q;
            main_v_d = skid_v_q;
            skid_v_d = 1'b0;
          end
          XferBoth: begin
            if (skid_v_q) begin
              main_d = skid_q;
              skid_d = in_if.data;
            end else begin
              main_d = in_if.data;
            end
          end
          XferNone: begin
          end
          default: begin
          end
        endcase
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      main_q   <= BUBBLE_DATA;
      skid_q   <= BUBBLE_DATA;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = main_q;
  assign occ_o        = occ_count(main_v_q, skid_v_q);

`ifdef PIPE_SKID_PERF_EN
  logic stall_inc, flush_inc;

  assign stall_inc = main_v_q && !out_if.ready && !hold && !jump;
  assign flush_inc = jump && (occ_o != '0);

  pipe_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk_i(clk_100MHz),
    .clr_i(rst),
    .inc_i(stall_inc),
    .cnt_o(stall_cnt_o)
  );

  pipe_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk_i(clk_100MHz),
    .clr_i(rst),
    .inc_i(flush_inc),
    .cnt_o(flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed vector bench for pipe_skid_stage: table-driven handshake checks plus counter sequences.

`ifndef HOLD_ENABLE
`define HOLD_ENABLE 1'b1
`endif
`ifndef JUMP_ENABLE
`define JUMP_ENABLE 1'b1
`endif
`ifndef RST_ENABLE
`define RST_ENABLE 1'b0
`endif

module tb_pipe_skid_stage;

  localparam int unsigned     DW  = 16;
  localparam int unsigned     CW  = 2;
  localparam logic [DW-1:0]   BUB = 16'hDEAD;
`ifdef PIPE_SKID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    bit            chk;
    bit            rst;
    bit            hold;
    bit            jump;
    bit            iv;
    logic [DW-1:0] id;
    bit            ordy;
    bit            eov;
    bit            eir;
    logic [1:0]    eocc;
    logic [DW-1:0] eod;
  } vec_t;

  logic          clk = 1'b0;
  logic          arst_n, hold_ena, jump_ena;
  logic [1:0]    occ;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int            errors = 0;
  int            total  = 0;
  vec_t          vecs[$];

  pipe_skid_stage_if #(.DATA_W(DW)) in_if ();
  pipe_skid_stage_if #(.DATA_W(DW)) out_if ();

  pipe_skid_stage #(
    .DATA_W(DW),
    .BUBBLE_DATA(BUB),
    .CNT_W(CW)
  ) dut (
    .clk_100MHz(clk),
    .arst_n(arst_n),
    .hold_ena_i(hold_ena),
    .jump_ena_i(jump_ena),
    .in_if(in_if),
    .out_if(out_if),
    .occ_o(occ),
    .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit chk, bit rst, bit hold, bit jump, bit iv, logic [DW-1:0] id,
                              bit ordy, bit eov, bit eir, logic [1:0] eocc, logic [DW-1:0] eod);
    vec_t v;
    v.chk = chk; v.rst = rst; v.hold = hold; v.jump = jump; v.iv = iv; v.id = id;
    v.ordy = ordy; v.eov = eov; v.eir = eir; v.eocc = eocc; v.eod = eod;
    return v;
  endfunction

  task automatic drive(bit rst, bit hold, bit jump, bit iv, logic [DW-1:0] id, bit ordy);
    arst_n       = rst  ? `RST_ENABLE  : ~`RST_ENABLE;
    hold_ena     = hold ? `HOLD_ENABLE : ~`HOLD_ENABLE;
    jump_ena     = jump ? `JUMP_ENABLE : ~`JUMP_ENABLE;
    in_if.valid  = iv;
    in_if.data   = id;
    out_if.ready = ordy;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Each row: inputs for one cycle, outputs expected before that cycle's edge.
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0, 1, 0, 1, 0, BUB));
    vecs.push_back(mk(1, 1, 0, 0, 0, 16'h0, 1, 0, 1, 0, BUB));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0, 1, 0, 1, 0, BUB));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'h1, 1, 0, 1, 0, BUB));
    for (int d = 2; d <= 8; d++) begin
      vecs.push_back(mk(1, 0, 0, 0, 1, DW'(d), 1, 1, 1, 1, DW'(d - 1)));
    end
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0,  1, 1, 1, 1, 16'h8));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0,  1, 0, 1, 0, BUB));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'hA,  0, 0, 1, 0, BUB));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'hB,  0, 1, 1, 1, 16'hA));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'hC,  0, 1, 0, 2, 16'hA));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'hC,  1, 1, 0, 2, 16'hA));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'hC,  1, 1, 1, 1, 16'hB));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0,  1, 1, 1, 1, 16'hC));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0,  0, 0, 1, 0, 16'hB));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'h11, 0, 0, 1, 0, 16'hB));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'h12, 0, 1, 1, 1, 16'h11));
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(1, 0, 1, 0, 1, 16'h13, 1, 0, 0, 2, 16'h11));
    end
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'h13, 1, 1, 0, 2, 16'h11));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'h13, 1, 1, 1, 1, 16'h12));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0,  0, 1, 1, 1, 16'h13));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'h14, 0, 1, 1, 1, 16'h13));
    vecs.push_back(mk(1, 0, 1, 1, 1, 16'h15, 1, 0, 0, 2, 16'h13));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0,  1, 0, 1, 0, BUB));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0,  1, 0, 1, 0, BUB));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'h21, 0, 0, 1, 0, BUB));
    vecs.push_back(mk(1, 1, 0, 0, 1, 16'h22, 0, 1, 1, 1, 16'h21));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0,  1, 0, 1, 0, BUB));
    vecs.push_back(mk(1, 0, 0, 0, 1, 16'h31, 0, 0, 1, 0, BUB));
    vecs.push_back(mk(1, 0, 0, 1, 1, 16'h32, 1, 0, 0, 1, 16'h31));
    vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0,  1, 0, 1, 0, BUB));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].hold, vecs[i].jump, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d out_valid", i), 32'(out_if.valid), 32'(vecs[i].eov));
        check($sformatf("v%0d in_ready", i),  32'(in_if.ready),  32'(vecs[i].eir));
        check($sformatf("v%0d occ", i),       32'(occ),          32'(vecs[i].eocc));
        check($sformatf("v%0d out_data", i),  32'(out_if.data),  32'(vecs[i].eod));
      end
    end

    // Counter sequence: reset, stall for longer than the 2-bit range, then flush twice.
    @(negedge clk);
    drive(1, 0, 0, 0, 16'h0, 0);
    @(negedge clk);
    #1;
    check("perf reset stall_cnt", 32'(stall_cnt), 32'd0);
    check("perf reset flush_cnt", 32'(flush_cnt), 32'd0);
    drive(0, 0, 0, 1, 16'h41, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 16'h0, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    check("perf stall saturate", 32'(stall_cnt), PERF ? 32'd3 : 32'd0);
    check("perf stall occ", 32'(occ), 32'd1);
    check("perf stall data", 32'(out_if.data), 32'h41);
    drive(0, 0, 1, 0, 16'h0, 0);
    #1;
    check("perf flush out_valid", 32'(out_if.valid), 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 16'h0, 0);
    #1;
    check("perf flush_cnt one", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);
    check("perf stall held", 32'(stall_cnt), PERF ? 32'd3 : 32'd0);
    check("perf flush occ", 32'(occ), 32'd0);
    check("perf flush data", 32'(out_if.data), 32'(BUB));
    drive(0, 0, 1, 0, 16'h0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 16'h0, 0);
    #1;
    check("perf empty flush", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Parametrised successor to the fixed-field pipeline registers (IF/ID, ID/EX, EX/MEM). It carries one opaque payload of DATA_W bits between two pipeline stages using a valid/ready handshake. A 2-entry skid buffer gives full throughput with a registered in_ready_o. Hold (stall) and jump (flush) controls keep the existing semantics, with an explicit priority order.

Parameters:
DATA_W, 160, payload width in bits (concatenated stage fields).
BUBBLE_DATA, {DATA_W{1'b0}}, payload value loaded on reset and on flush (NOP/bubble encoding).
CNT_W, 16, width of the performance counters (used only with PIPE_SKID_PERF_EN).

Ports:
clk_100MHz  in  1  core clock, rising edge.
arst_n  in  1  reset; synchronous, active-low (the name is historical; it is sampled on the clk_100MHz edge only).
hold_ena_i  in  1  stall; active level is `HOLD_ENABLE.
jump_ena_i  in  1  flush; active level is `JUMP_ENABLE.
in_valid_i  in  1  upstream payload valid.
in_ready_o  out  1  stage can accept.
in_data_i  in  DATA_W  upstream payload.
out_valid_o  out  1  payload available downstream.
out_ready_i  in  1  downstream accepts.
out_data_o  out  DATA_W  head payload.
occ_o  out  2  entries held (0..2).
stall_cnt_o  out  CNT_W  perf only: backpressure cycles.
flush_cnt_o  out  CNT_W  perf only: flush events.

Behaviour:
- Storage:
  - main_q/main_v: head entry, drives out_data_o.
  - skid_q/skid_v: overflow entry.
  - Invariant: skid_v implies main_v.
- Reset (arst_n == `RST_ENABLE at the clock edge):
  - main_v=0, skid_v=0, main_q=skid_q=BUBBLE_DATA.
  - Outputs next cycle: out_valid_o=0, in_ready_o=1, occ_o=0, out_data_o=BUBBLE_DATA, counters=0.
  - Reset overrides everything, including mid-transfer.
- Handshake outputs (combinational from registers plus controls):
  - in_ready_o = !skid_v && !hold && !jump.
  - out_valid_o = main_v && !hold && !jump.
  - push = in_valid_i && in_ready_o; pop = out_valid_o && out_ready_i.
- Priority: reset > jump > hold > normal.
  - This is a deliberate change: flush wins over a simultaneous stall, so a redirect is never lost.
- Flush (jump active, not in reset):
  - Next edge: main_v=skid_v=0, both data registers = BUBBLE_DATA.
  - No transfer occurs in the flush cycle on either side.
- Hold (jump inactive): all registers keep their value; no transfer on either side.
- Normal operation, per edge:
  - push & !pop: if !main_v then main<=in, main_v=1; else skid<=in, skid_v=1.
  - pop & !push: main<=skid, main_v<=skid_v, skid_v=0. Vacated data registers keep their old contents.
  - push & pop: if skid_v then main<=skid, skid<=in; else main<=in.
  - neither: no change.
- Latency and throughput:
  - 1 cycle from an accepted input to out_valid_o.
  - Sustained 1 transfer/cycle when out_ready_i=1.
  - The skid entry absorbs the one payload accepted in the cycle downstream deasserts ready.
- Full/empty boundaries:
  - occ_o = main_v + skid_v.
  - occ=2: in_ready_o=0.
  - occ=0: out_valid_o=0, and out_data_o shows the last or bubble value. Downstream must qualify with valid.
- Payload ordering is strict FIFO; no payload is dropped except by flush or reset.
- in_valid_i may drop without a transfer; no upstream stability rule is required.

Optional Feature:
- Macro: PIPE_SKID_PERF_EN.
- Defined:
  - stall_cnt_o increments each cycle with main_v && !out_ready_i && !hold && !jump.
  - flush_cnt_o increments on each cycle jump is active with occ_o != 0.
  - Both counters saturate at all-ones and clear on reset only.
- Undefined: stall_cnt_o and flush_cnt_o are tied to 0 and no counter flops exist.

Decomposition:
- `HOLD_ENABLE, `JUMP_ENABLE, `RST_ENABLE and the bubble encodings (`ZERO_INST, `CPU_RESET_ADDR packing) stay in the shared define.v.
- Per-stage BUBBLE_DATA is built from those constants at instantiation.
- One sub-module: pipe_sat_cnt (CNT_W saturating counter with inc and sync clear), instantiated twice under PIPE_SKID_PERF_EN.

Test Plan:
- Reset then idle: arst_n=0 for 2 cycles, then 1 -> out_valid_o=0, in_ready_o=1, occ_o=0, out_data_o=BUBBLE_DATA.
- Streaming: push 0x1..0x8 on consecutive cycles with out_ready_i=1 -> out_data_o=0x1..0x8 one cycle later each, occ_o=1, no bubbles.
- Backpressure: push 0xA,0xB,0xC with out_ready_i=0 -> 0xA,0xB accepted, in_ready_o=0, occ_o=2, 0xC held upstream; release -> output 0xA,0xB,0xC in order.
- Hold: occ=2, hold_ena_i=1 for 3 cycles with valid/ready high -> no transfer, state unchanged; after release, order preserved.
- Flush: occ=2, jump_ena_i and hold_ena_i both active 1 cycle -> next cycle occ_o=0, out_data_o=BUBBLE_DATA, the pending input is not accepted; with PERF, flush_cnt_o=1.
- PERF saturation: CNT_W=2, out_ready_i=0 with main_v=1 for 6 cycles -> stall_cnt_o stops at 3.
